// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory stage: datapath widths, opcodes, memory map,
// FSM encoding, the registered Writeback bundle and a condition-code helper.
// No logic; imported by memory_stage and its testbench.
package memory_stage_pkg;

  localparam int PC_WIDTH        = 16;
  localparam int IR_WIDTH        = 16;
  localparam int OPCODE_WIDTH    = 8;
  localparam int REG_WIDTH       = 16;
  localparam int VREG_ID_WIDTH   = 6;
  localparam int VREG_WIDTH      = 64;
  localparam int DMEM_ADDR_WIDTH = 10;

  // Memory-mapped I/O word addresses.
  localparam logic [15:0] LEDR_ADDR = 16'hFFF0;
  localparam logic [15:0] HEX_ADDR  = 16'hFFF2;

  // Opcodes seen by this stage; anything else is passed through.
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB = 8'h10;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 8'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_STB = 8'h12;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW = 8'h13;

  // IDLE: ready for a new op (low byte of a word op). HIGH: high byte of a word op.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } mem_state_t;

  // Registered bundle handed to Writeback.
  typedef struct packed {
    logic                     lock;
    logic [PC_WIDTH-1:0]      pc;
    logic [IR_WIDTH-1:0]      ir;
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [3:0]               dest_idx;
    logic [VREG_ID_WIDTH-1:0] dest_vidx;
    logic [REG_WIDTH-1:0]     dest_value;
    logic [2:0]               cc;
    logic [VREG_WIDTH-1:0]    vec_value;
    logic                     valid;
    logic                     regwen;
    logic                     vregwen;
    logic                     ccwen;
  } wb_bundle_t;

  // Condition codes {neg, zero, pos} of a loaded value.
  function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] v);
    logic w_neg;
    logic w_zero;
    w_neg  = v[REG_WIDTH-1];
    w_zero = (v == '0);
    return {w_neg, w_zero, ~w_neg & ~w_zero};
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide data RAM, one shared address for the async read and the write port.
// Latency: read is combinational; write lands on the falling edge of i_clk.
// Backpressure: none; the caller gates i_we. Contents are never cleared.
// Ports: i_clk (write clock, falling edge), i_we, i_addr, i_wdata, o_rdata.
module dmem_byte_ram #(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];

  always_ff @(negedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: LDB/LDW/STB/STW against a byte RAM plus LED/HEX I/O regs.
// Latency: 1 falling edge for byte ops and pass-through, 2 for word ops.
// Backpressure: O_MEMStall_Signal holds Execute for word ops; I_GPUStallSignal freezes all state.
// Ports: I_CLOCK/I_RESET, Execute bundle in (I_*), Writeback bundle out (O_*),
//        O_LEDR/O_HEX I/O registers, O_MEMStall_Signal and O_RegWEn_Signal (combinational).
import memory_stage_pkg::*;

module memory_stage #(
  parameter int          DMEM_AW = DMEM_ADDR_WIDTH,
  parameter logic [15:0] LEDR_A  = LEDR_ADDR,
  parameter logic [15:0] HEX_A   = HEX_ADDR
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic [PC_WIDTH-1:0]      I_PC,
  input  logic [IR_WIDTH-1:0]      I_IR,
  input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
  input  logic [3:0]               I_DestRegIdx,
  input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
  input  logic [REG_WIDTH-1:0]     I_DestValue,
  input  logic [REG_WIDTH-1:0]     I_MARValue,
  input  logic [REG_WIDTH-1:0]     I_MDRValue,
  input  logic [2:0]               I_CCValue,
  input  logic [VREG_WIDTH-1:0]    I_VecDestValue,
  input  logic                     I_EX_Valid,
  input  logic                     I_RegWEn,
  input  logic                     I_VRegWEn,
  input  logic                     I_CCWEn,
  input  logic                     I_GPUStallSignal,
  output logic                     O_LOCK,
  output logic [PC_WIDTH-1:0]      O_PC,
  output logic [IR_WIDTH-1:0]      O_IR,
  output logic [OPCODE_WIDTH-1:0]  O_Opcode,
  output logic [3:0]               O_DestRegIdx,
  output logic [VREG_ID_WIDTH-1:0] O_DestVRegIdx,
  output logic [REG_WIDTH-1:0]     O_DestValue,
  output logic [2:0]               O_CCValue,
  output logic [VREG_WIDTH-1:0]    O_VecDestValue,
  output logic                     O_MEM_Valid,
  output logic                     O_RegWEn,
  output logic                     O_VRegWEn,
  output logic                     O_CCWEn,
  output logic [15:0]              O_LEDR,
  output logic [15:0]              O_HEX,
  output logic                     O_MEMStall_Signal,
  output logic                     O_RegWEn_Signal
);

  mem_state_t r_state;
  mem_state_t w_state_nxt;
  wb_bundle_t r_wb;
  wb_bundle_t w_wb_nxt;
  logic [7:0]  r_lo_byte;
  logic [15:0] r_ledr;
  logic [15:0] r_hex;

  logic        w_accept;
  logic        w_is_ldb, w_is_ldw, w_is_stb, w_is_stw, w_is_word;
  logic        w_in_high;
  logic [15:0] w_word_addr;
  logic [15:0] w_addr;
  logic        w_in_ram;
  logic        w_is_ledr, w_is_hex;
  logic        w_ram_we;
  logic [7:0]  w_ram_wdata;
  logic [7:0]  w_ram_rdata;
  logic [7:0]  w_rd_byte;
  logic [15:0] w_ldb_val;
  logic [15:0] w_ldw_val;
  logic        w_update;

  assign w_accept  = I_LOCK & I_EX_Valid;
  assign w_is_ldb  = (I_Opcode == OP_LDB);
  assign w_is_ldw  = (I_Opcode == OP_LDW);
  assign w_is_stb  = (I_Opcode == OP_STB);
  assign w_is_stw  = (I_Opcode == OP_STW);
  assign w_is_word = w_is_ldw | w_is_stw;
  assign w_in_high = (r_state == ST_HIGH);
  // State updates of any kind are suppressed by reset and by a downstream stall.
  assign w_update  = ~I_RESET & ~I_GPUStallSignal;

  // Word ops ignore MAR[0]; the byte lane is chosen by the FSM state.
  assign w_word_addr = {I_MARValue[15:1], 1'b0};
  assign w_addr      = w_is_word ? {I_MARValue[15:1], w_in_high} : I_MARValue;
  assign w_in_ram    = ~|w_addr[15:DMEM_AW];
  // I/O is word-only; byte ops to these addresses fall outside RAM and read as 0.
  assign w_is_ledr   = w_is_word & (w_word_addr == LEDR_A);
  assign w_is_hex    = w_is_word & (w_word_addr == HEX_A);

  assign w_ram_we    = w_update & w_accept & w_in_ram & (w_is_stb | w_is_stw);
  assign w_ram_wdata = (w_is_stw & w_in_high) ? I_MDRValue[15:8] : I_MDRValue[7:0];

  dmem_byte_ram #(.AW(DMEM_AW)) u_ram (
    .i_clk   (I_CLOCK),
    .i_we    (w_ram_we),
    .i_addr  (w_addr[DMEM_AW-1:0]),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign w_rd_byte = w_in_ram ? w_ram_rdata : 8'h00;
  assign w_ldb_val = {{8{w_rd_byte[7]}}, w_rd_byte};
  assign w_ldw_val = w_is_ledr ? r_ledr :
                     w_is_hex  ? r_hex  :
                     w_in_ram  ? {w_ram_rdata, r_lo_byte} : 16'h0000;

  // ---------------- FSM ----------------
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      r_state <= ST_IDLE;
    end else if (!I_GPUStallSignal) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_word) w_state_nxt = ST_HIGH;
      // HIGH always finishes (or is abandoned when Execute drops the op).
      ST_HIGH: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- Writeback bundle ----------------
  always_comb begin
    w_wb_nxt            = '0;
    w_wb_nxt.lock       = I_LOCK;
    w_wb_nxt.pc         = I_PC;
    w_wb_nxt.ir         = I_IR;
    w_wb_nxt.opcode     = I_Opcode;
    w_wb_nxt.dest_idx   = I_DestRegIdx;
    w_wb_nxt.dest_vidx  = I_DestVRegIdx;
    w_wb_nxt.dest_value = I_DestValue;
    w_wb_nxt.cc         = I_CCValue;
    w_wb_nxt.vec_value  = I_VecDestValue;
    w_wb_nxt.valid      = I_LOCK & I_EX_Valid;
    w_wb_nxt.regwen     = I_LOCK & I_RegWEn;
    w_wb_nxt.vregwen    = I_LOCK & I_VRegWEn;
    w_wb_nxt.ccwen      = I_LOCK & I_CCWEn;
    if (w_accept) begin
      if (w_is_ldb) begin
        w_wb_nxt.dest_value = w_ldb_val;
        w_wb_nxt.cc         = cc_of(w_ldb_val);
        w_wb_nxt.regwen     = 1'b1;
        w_wb_nxt.ccwen      = 1'b1;
      end else if (w_is_stb) begin
        w_wb_nxt.regwen = 1'b0;
        w_wb_nxt.ccwen  = 1'b0;
      end else if (w_is_word && !w_in_high) begin
        // First half of a word op: bubble to Writeback.
        w_wb_nxt.valid   = 1'b0;
        w_wb_nxt.regwen  = 1'b0;
        w_wb_nxt.vregwen = 1'b0;
        w_wb_nxt.ccwen   = 1'b0;
      end else if (w_is_ldw) begin
        w_wb_nxt.dest_value = w_ldw_val;
        w_wb_nxt.cc         = cc_of(w_ldw_val);
        w_wb_nxt.regwen     = 1'b1;
        w_wb_nxt.ccwen      = 1'b1;
      end else if (w_is_stw) begin
        w_wb_nxt.regwen = 1'b0;
        w_wb_nxt.ccwen  = 1'b0;
      end
    end
  end

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      r_wb      <= '0;
      r_lo_byte <= 8'h00;
      r_ledr    <= 16'h0000;
      r_hex     <= 16'h0000;
    end else if (!I_GPUStallSignal) begin
      r_wb <= w_wb_nxt;
      if (w_accept && w_is_ldw && !w_in_high) begin
        r_lo_byte <= w_rd_byte;
      end
      if (w_accept && w_is_stw && w_in_high && w_is_ledr) begin
        r_ledr <= I_MDRValue;
      end
      if (w_accept && w_is_stw && w_in_high && w_is_hex) begin
        r_hex <= I_MDRValue;
      end
    end
  end

  assign O_LOCK         = r_wb.lock;
  assign O_PC           = r_wb.pc;
  assign O_IR           = r_wb.ir;
  assign O_Opcode       = r_wb.opcode;
  assign O_DestRegIdx   = r_wb.dest_idx;
  assign O_DestVRegIdx  = r_wb.dest_vidx;
  assign O_DestValue    = r_wb.dest_value;
  assign O_CCValue      = r_wb.cc;
  assign O_VecDestValue = r_wb.vec_value;
  assign O_MEM_Valid    = r_wb.valid;
  assign O_RegWEn       = r_wb.regwen;
  assign O_VRegWEn      = r_wb.vregwen;
  assign O_CCWEn        = r_wb.ccwen;
  assign O_LEDR         = r_ledr;
  assign O_HEX          = r_hex;

  assign O_MEMStall_Signal = I_GPUStallSignal |
                             (~w_in_high & w_accept & w_is_word & ~I_RESET);
  assign O_RegWEn_Signal   = w_accept & (I_RegWEn | w_is_ldb | w_is_ldw);

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage: reset, word/byte RAM access, I/O, GPU stall,
// reset abort and pass-through. Inputs change on the rising edge, the DUT updates on
// the falling edge, and outputs are compared at the following rising edge.
import memory_stage_pkg::*;

module tb_memory_stage;

  logic                     I_CLOCK = 1'b0;
  logic                     I_RESET;
  logic                     I_LOCK;
  logic [PC_WIDTH-1:0]      I_PC;
  logic [IR_WIDTH-1:0]      I_IR;
  logic [OPCODE_WIDTH-1:0]  I_Opcode;
  logic [3:0]               I_DestRegIdx;
  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx;
  logic [REG_WIDTH-1:0]     I_DestValue;
  logic [REG_WIDTH-1:0]     I_MARValue;
  logic [REG_WIDTH-1:0]     I_MDRValue;
  logic [2:0]               I_CCValue;
  logic [VREG_WIDTH-1:0]    I_VecDestValue;
  logic                     I_EX_Valid, I_RegWEn, I_VRegWEn, I_CCWEn, I_GPUStallSignal;
  logic                     O_LOCK;
  logic [PC_WIDTH-1:0]      O_PC;
  logic [IR_WIDTH-1:0]      O_IR;
  logic [OPCODE_WIDTH-1:0]  O_Opcode;
  logic [3:0]               O_DestRegIdx;
  logic [VREG_ID_WIDTH-1:0] O_DestVRegIdx;
  logic [REG_WIDTH-1:0]     O_DestValue;
  logic [2:0]               O_CCValue;
  logic [VREG_WIDTH-1:0]    O_VecDestValue;
  logic                     O_MEM_Valid, O_RegWEn, O_VRegWEn, O_CCWEn;
  logic [15:0]              O_LEDR, O_HEX;
  logic                     O_MEMStall_Signal, O_RegWEn_Signal;

  int checks = 0;
  int errors = 0;

  memory_stage dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_PC(I_PC), .I_IR(I_IR),
    .I_Opcode(I_Opcode), .I_DestRegIdx(I_DestRegIdx), .I_DestVRegIdx(I_DestVRegIdx),
    .I_DestValue(I_DestValue), .I_MARValue(I_MARValue), .I_MDRValue(I_MDRValue),
    .I_CCValue(I_CCValue), .I_VecDestValue(I_VecDestValue), .I_EX_Valid(I_EX_Valid),
    .I_RegWEn(I_RegWEn), .I_VRegWEn(I_VRegWEn), .I_CCWEn(I_CCWEn),
    .I_GPUStallSignal(I_GPUStallSignal),
    .O_LOCK(O_LOCK), .O_PC(O_PC), .O_IR(O_IR), .O_Opcode(O_Opcode),
    .O_DestRegIdx(O_DestRegIdx), .O_DestVRegIdx(O_DestVRegIdx), .O_DestValue(O_DestValue),
    .O_CCValue(O_CCValue), .O_VecDestValue(O_VecDestValue), .O_MEM_Valid(O_MEM_Valid),
    .O_RegWEn(O_RegWEn), .O_VRegWEn(O_VRegWEn), .O_CCWEn(O_CCWEn),
    .O_LEDR(O_LEDR), .O_HEX(O_HEX), .O_MEMStall_Signal(O_MEMStall_Signal),
    .O_RegWEn_Signal(O_RegWEn_Signal)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  // One DUT update, then return at the next rising edge for checking/driving.
  task automatic tick();
    @(negedge I_CLOCK);
    @(posedge I_CLOCK);
  endtask

  task automatic idle_inputs();
    I_LOCK = 1'b0; I_EX_Valid = 1'b0; I_PC = '0; I_IR = '0; I_Opcode = '0;
    I_DestRegIdx = '0; I_DestVRegIdx = '0; I_DestValue = '0; I_MARValue = '0;
    I_MDRValue = '0; I_CCValue = '0; I_VecDestValue = '0; I_RegWEn = 1'b0;
    I_VRegWEn = 1'b0; I_CCWEn = 1'b0; I_GPUStallSignal = 1'b0;
  endtask

  task automatic drive(input logic [7:0] op, input logic [15:0] mar, input logic [15:0] mdr);
    idle_inputs();
    I_LOCK = 1'b1; I_EX_Valid = 1'b1; I_Opcode = op; I_MARValue = mar; I_MDRValue = mdr;
  endtask

  task automatic test_reset();
    idle_inputs();
    I_RESET = 1'b1;
    tick();
    tick();
    checks++; if (O_MEM_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", O_MEM_Valid); end
    checks++; if ({O_RegWEn, O_CCWEn, O_VRegWEn, O_LOCK} !== 4'b0) begin errors++; $display("FAIL reset_wen got %b exp 0000", {O_RegWEn, O_CCWEn, O_VRegWEn, O_LOCK}); end
    checks++; if ({O_DestValue, O_LEDR, O_HEX, O_PC} !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {O_DestValue, O_LEDR, O_HEX, O_PC}); end
    checks++; if (O_MEMStall_Signal !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", O_MEMStall_Signal); end
    I_RESET = 1'b0;
  endtask

  task automatic test_word_mem();
    drive(OP_STW, 16'h0010, 16'hBEEF);
    #1;
    checks++; if (O_MEMStall_Signal !== 1'b1) begin errors++; $display("FAIL stw_stall_lo got %b exp 1", O_MEMStall_Signal); end
    tick();
    checks++; if (O_MEMStall_Signal !== 1'b0) begin errors++; $display("FAIL stw_stall_hi got %b exp 0", O_MEMStall_Signal); end
    checks++; if (O_MEM_Valid !== 1'b0) begin errors++; $display("FAIL stw_bubble got %b exp 0", O_MEM_Valid); end
    tick();
    checks++; if ({O_MEM_Valid, O_RegWEn, O_CCWEn} !== 3'b100) begin errors++; $display("FAIL stw_done got %b exp 100", {O_MEM_Valid, O_RegWEn, O_CCWEn}); end
    checks++; if (dut.u_ram.r_mem[10'h010] !== 8'hEF) begin errors++; $display("FAIL stw_ram_lo got %h exp ef", dut.u_ram.r_mem[10'h010]); end
    checks++; if (dut.u_ram.r_mem[10'h011] !== 8'hBE) begin errors++; $display("FAIL stw_ram_hi got %h exp be", dut.u_ram.r_mem[10'h011]); end
    drive(OP_LDW, 16'h0011, 16'h0000);
    #1;
    checks++; if (O_MEMStall_Signal !== 1'b1) begin errors++; $display("FAIL ldw_stall_lo got %b exp 1", O_MEMStall_Signal); end
    checks++; if (O_RegWEn_Signal !== 1'b1) begin errors++; $display("FAIL ldw_regwen_sig got %b exp 1", O_RegWEn_Signal); end
    tick();
    checks++; if (O_MEMStall_Signal !== 1'b0) begin errors++; $display("FAIL ldw_stall_hi got %b exp 0", O_MEMStall_Signal); end
    tick();
    checks++; if (O_DestValue !== 16'hBEEF) begin errors++; $display("FAIL ldw_data got %h exp beef", O_DestValue); end
    checks++; if ({O_MEM_Valid, O_RegWEn, O_CCWEn, O_CCValue} !== 6'b111100) begin errors++; $display("FAIL ldw_flags got %b exp 111100", {O_MEM_Valid, O_RegWEn, O_CCWEn, O_CCValue}); end
    idle_inputs();
  endtask

  task automatic test_byte_mem();
    drive(OP_STB, 16'h0020, 16'h1280);
    #1;
    checks++; if (O_MEMStall_Signal !== 1'b0) begin errors++; $display("FAIL stb_stall got %b exp 0", O_MEMStall_Signal); end
    tick();
    checks++; if ({O_MEM_Valid, O_RegWEn, O_CCWEn} !== 3'b100) begin errors++; $display("FAIL stb_done got %b exp 100", {O_MEM_Valid, O_RegWEn, O_CCWEn}); end
    checks++; if (dut.u_ram.r_mem[10'h020] !== 8'h80) begin errors++; $display("FAIL stb_ram got %h exp 80", dut.u_ram.r_mem[10'h020]); end
    drive(OP_LDB, 16'h0020, 16'h0000);
    tick();
    checks++; if (O_DestValue !== 16'hFF80) begin errors++; $display("FAIL ldb_neg got %h exp ff80", O_DestValue); end
    checks++; if ({O_MEM_Valid, O_RegWEn, O_CCWEn, O_CCValue} !== 6'b111100) begin errors++; $display("FAIL ldb_neg_flags got %b exp 111100", {O_MEM_Valid, O_RegWEn, O_CCWEn, O_CCValue}); end
    drive(OP_STB, 16'h0020, 16'hFF00);
    tick();
    drive(OP_LDB, 16'h0020, 16'h0000);
    tick();
    checks++; if (O_DestValue !== 16'h0000) begin errors++; $display("FAIL ldb_zero got %h exp 0000", O_DestValue); end
    checks++; if (O_CCValue !== 3'b010) begin errors++; $display("FAIL ldb_zero_cc got %b exp 010", O_CCValue); end
    idle_inputs();
  endtask

  task automatic test_io();
    drive(OP_STB, 16'h03F0, 16'h0011);
    tick();
    drive(OP_STW, 16'hFFF0, 16'h00A5);
    tick();
    tick();
    checks++; if (O_LEDR !== 16'h00A5) begin errors++; $display("FAIL ledr got %h exp 00a5", O_LEDR); end
    checks++; if (O_HEX !== 16'h0000) begin errors++; $display("FAIL hex_untouched got %h exp 0000", O_HEX); end
    checks++; if (dut.u_ram.r_mem[10'h3F0] !== 8'h11) begin errors++; $display("FAIL io_ram_alias got %h exp 11", dut.u_ram.r_mem[10'h3F0]); end
    drive(OP_LDW, 16'hFFF0, 16'h0000);
    tick();
    tick();
    checks++; if (O_DestValue !== 16'h00A5) begin errors++; $display("FAIL ldw_ledr got %h exp 00a5", O_DestValue); end
    checks++; if (O_CCValue !== 3'b001) begin errors++; $display("FAIL ldw_ledr_cc got %b exp 001", O_CCValue); end
    drive(OP_LDB, 16'hFFF0, 16'h0000);
    tick();
    checks++; if (O_DestValue !== 16'h0000) begin errors++; $display("FAIL ldb_io got %h exp 0000", O_DestValue); end
    drive(OP_LDW, 16'h8000, 16'h0000);
    tick();
    tick();
    checks++; if ({O_MEM_Valid, O_DestValue} !== 17'h10000) begin errors++; $display("FAIL ldw_unmapped got %h exp 10000", {O_MEM_Valid, O_DestValue}); end
    idle_inputs();
  endtask

  task automatic test_gpu_stall();
    drive(OP_LDW, 16'h0010, 16'h0000);
    tick();
    I_GPUStallSignal = 1'b1;
    #1;
    checks++; if (O_MEMStall_Signal !== 1'b1) begin errors++; $display("FAIL gpu_stall_out got %b exp 1", O_MEMStall_Signal); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({O_MEM_Valid, dut.r_state} !== {1'b0, ST_HIGH}) begin errors++; $display("FAIL gpu_frozen%0d got %b exp 01", i, {O_MEM_Valid, dut.r_state}); end
    end
    I_GPUStallSignal = 1'b0;
    tick();
    checks++; if ({O_MEM_Valid, O_DestValue} !== {1'b1, 16'hBEEF}) begin errors++; $display("FAIL gpu_release got %h exp 1beef", {O_MEM_Valid, O_DestValue}); end
    idle_inputs();
  endtask

  task automatic test_reset_abort();
    drive(OP_STB, 16'h0031, 16'h005A);
    tick();
    drive(OP_STW, 16'h0030, 16'h1234);
    tick();
    I_RESET = 1'b1;
    #1;
    checks++; if (O_MEMStall_Signal !== 1'b0) begin errors++; $display("FAIL abort_stall got %b exp 0", O_MEMStall_Signal); end
    tick();
    checks++; if (dut.u_ram.r_mem[10'h030] !== 8'h34) begin errors++; $display("FAIL abort_lo got %h exp 34", dut.u_ram.r_mem[10'h030]); end
    checks++; if (dut.u_ram.r_mem[10'h031] !== 8'h5A) begin errors++; $display("FAIL abort_hi got %h exp 5a", dut.u_ram.r_mem[10'h031]); end
    checks++; if ({O_MEM_Valid, dut.r_state} !== {1'b0, ST_IDLE}) begin errors++; $display("FAIL abort_state got %b exp 00", {O_MEM_Valid, dut.r_state}); end
    checks++; if (O_LEDR !== 16'h0000) begin errors++; $display("FAIL abort_ledr got %h exp 0000", O_LEDR); end
    idle_inputs();
    I_RESET = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    drive(OP_ADD, 16'h0000, 16'h0000);
    I_DestValue = 16'h1234; I_RegWEn = 1'b1; I_CCWEn = 1'b1; I_CCValue = 3'b001;
    I_PC = 16'h0042; I_DestRegIdx = 4'd5;
    tick();
    checks++; if ({O_MEM_Valid, O_RegWEn, O_CCWEn, O_CCValue} !== 6'b111001) begin errors++; $display("FAIL pass_flags got %b exp 111001", {O_MEM_Valid, O_RegWEn, O_CCWEn, O_CCValue}); end
    checks++; if ({O_DestValue, O_PC, O_DestRegIdx} !== {16'h1234, 16'h0042, 4'd5}) begin errors++; $display("FAIL pass_data got %h exp 123400425", {O_DestValue, O_PC, O_DestRegIdx}); end
    I_LOCK = 1'b0;
    tick();
    checks++; if ({O_MEM_Valid, O_RegWEn, O_CCWEn} !== 3'b000) begin errors++; $display("FAIL nolock got %b exp 000", {O_MEM_Valid, O_RegWEn, O_CCWEn}); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    I_RESET = 1'b1;
    @(posedge I_CLOCK);
    test_reset();
    test_word_mem();
    test_byte_mem();
    test_io();
    test_gpu_stall();
    test_reset_abort();
    test_passthrough();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
